// File: rtl/dp_mem_ctrl_pkg.sv
// Shared types for the dual-port memory controller: request opcode, per-port
// response state and a request bundle.
package dp_mem_ctrl_pkg;

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } mem_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RSP  = 1'b1
  } port_state_e;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 8;

  typedef struct packed {
    mem_op_e                 op;
    logic [ADDR_W_DEF-1:0]   addr;
    logic [DATA_W_DEF-1:0]   wdata;
  } mem_req_t;

  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/dp_mem_ctrl_if.sv
// One request/response port of the dual-port memory controller.
interface dp_mem_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dp_mem_ctrl_array.sv
// Two-port synchronous RAM, read-before-write, no reset on contents.
module dp_mem_ctrl_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              i_a_we,
  input  logic              i_a_re,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic [DATA_W-1:0] o_a_rdata,
  input  logic              i_b_we,
  input  logic              i_b_re,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic [DATA_W-1:0] o_b_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_a_q;
  logic [DATA_W-1:0] r_b_q;

  always_ff @(posedge clk) begin
    if (i_a_we) r_mem[i_a_addr] <= i_a_wdata;
    if (i_b_we) r_mem[i_b_addr] <= i_b_wdata;
  end

  // Output registers only load on an accepted read so a stalled response holds.
  always_ff @(posedge clk) begin
    if (i_a_re) r_a_q <= r_mem[i_a_addr];
    if (i_b_re) r_b_q <= r_mem[i_b_addr];
  end

  assign o_a_rdata = r_a_q;
  assign o_b_rdata = r_b_q;

endmodule

// File: rtl/dp_mem_ctrl.sv
// Dual-port memory controller: two valid/ready ports over one array, write
// collision arbitration and a saturating collision-stall counter.
module dp_mem_ctrl
  import dp_mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 2**ADDR_W,
  parameter bit          PRIO_A = 1'b1
) (
  input  logic                clk,
  input  logic                rstn,
  dp_mem_ctrl_if.slave        a_if,
  dp_mem_ctrl_if.slave        b_if,
  output logic [15:0]         coll_cnt
);

  logic              w_valid     [2];
  logic              w_rsp_ready [2];
  mem_op_e           w_op        [2];
  logic [ADDR_W-1:0] w_addr      [2];
  logic [DATA_W-1:0] w_wdata     [2];
  logic              w_in_range  [2];
  logic              w_lose      [2];
  logic              w_ready     [2];
  logic              w_acc       [2];
  logic              w_mem_we    [2];
  logic              w_mem_re    [2];
  logic [DATA_W-1:0] w_q         [2];
  port_state_e       w_state_nxt [2];
  port_state_e       r_state     [2];
  logic              r_err       [2];
  logic [15:0]       r_coll_cnt;
  logic              w_same_wr;
  logic              w_coll;

  assign w_valid[0]     = a_if.req_valid;
  assign w_valid[1]     = b_if.req_valid;
  assign w_rsp_ready[0] = a_if.rsp_ready;
  assign w_rsp_ready[1] = b_if.rsp_ready;
  assign w_op[0]        = a_if.req_we ? MEM_WR : MEM_RD;
  assign w_op[1]        = b_if.req_we ? MEM_WR : MEM_RD;
  assign w_addr[0]      = a_if.req_addr;
  assign w_addr[1]      = b_if.req_addr;
  assign w_wdata[0]     = a_if.req_wdata;
  assign w_wdata[1]     = b_if.req_wdata;
  assign w_in_range[0]  = addr_ok(32'(w_addr[0]), DEPTH);
  assign w_in_range[1]  = addr_ok(32'(w_addr[1]), DEPTH);

  // Loss is qualified by the other port's valid only, so ready never looks at
  // its own port's valid.
  assign w_same_wr = (w_op[0] == MEM_WR) && (w_op[1] == MEM_WR) &&
                     (w_addr[0] == w_addr[1]) && w_in_range[0];
  assign w_coll    = w_valid[0] && w_valid[1] && w_same_wr;
  assign w_lose[0] = !PRIO_A && w_valid[1] && w_same_wr;
  assign w_lose[1] =  PRIO_A && w_valid[0] && w_same_wr;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      w_ready[p]     = !w_lose[p] && ((r_state[p] == IDLE) || w_rsp_ready[p]);
      w_acc[p]       = w_valid[p] && w_ready[p];
      w_mem_we[p]    = w_acc[p] && (w_op[p] == MEM_WR) && w_in_range[p];
      w_mem_re[p]    = w_acc[p] && (w_op[p] == MEM_RD) && w_in_range[p];
      w_state_nxt[p] = r_state[p];
      case (r_state[p])
        IDLE: if (w_acc[p] && (w_op[p] == MEM_RD)) w_state_nxt[p] = RSP;
        RSP:  if (w_rsp_ready[p] && !(w_acc[p] && (w_op[p] == MEM_RD)))
                w_state_nxt[p] = IDLE;
        default: w_state_nxt[p] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned p = 0; p < 2; p++) begin
        r_state[p] <= IDLE;
        r_err[p]   <= 1'b0;
      end
      r_coll_cnt <= '0;
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        r_state[p] <= w_state_nxt[p];
        if (w_acc[p] && (w_op[p] == MEM_RD)) r_err[p] <= !w_in_range[p];
      end
      if (w_coll && (r_coll_cnt != '1)) r_coll_cnt <= r_coll_cnt + 16'd1;
    end
  end

  dp_mem_ctrl_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk       (clk),
    .i_a_we    (w_mem_we[0]),
    .i_a_re    (w_mem_re[0]),
    .i_a_addr  (w_addr[0]),
    .i_a_wdata (w_wdata[0]),
    .o_a_rdata (w_q[0]),
    .i_b_we    (w_mem_we[1]),
    .i_b_re    (w_mem_re[1]),
    .i_b_addr  (w_addr[1]),
    .i_b_wdata (w_wdata[1]),
    .o_b_rdata (w_q[1])
  );

  // Response data is masked to zero when idle or on an out-of-range read.
  assign a_if.req_ready = w_ready[0];
  assign a_if.rsp_valid = (r_state[0] == RSP);
  assign a_if.rsp_err   = (r_state[0] == RSP) && r_err[0];
  assign a_if.rsp_rdata = ((r_state[0] == RSP) && !r_err[0]) ? w_q[0] : '0;
  assign b_if.req_ready = w_ready[1];
  assign b_if.rsp_valid = (r_state[1] == RSP);
  assign b_if.rsp_err   = (r_state[1] == RSP) && r_err[1];
  assign b_if.rsp_rdata = ((r_state[1] == RSP) && !r_err[1]) ? w_q[1] : '0;
  assign coll_cnt       = r_coll_cnt;

endmodule

// File: tb/tb_dp_mem_ctrl.sv
// Bench for dp_mem_ctrl: directed scenarios with literal expectations, then
// random traffic on both ports checked every cycle against a transaction model.
module tb_dp_mem_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 200;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] coll_cnt;

  dp_mem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) a_if ();
  dp_mem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) b_if ();

  dp_mem_ctrl #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DEPTH),
    .PRIO_A (1'b1)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .a_if     (a_if),
    .b_if     (b_if),
    .coll_cnt (coll_cnt)
  );

  always #5 clk = ~clk;

  // Stimulus, index 0 = port A, 1 = port B
  logic          d_valid [2];
  logic          d_we    [2];
  logic [AW-1:0] d_addr  [2];
  logic [DW-1:0] d_wdata [2];
  logic          d_rrdy  [2];

  assign a_if.req_valid = d_valid[0];
  assign a_if.req_we    = d_we[0];
  assign a_if.req_addr  = d_addr[0];
  assign a_if.req_wdata = d_wdata[0];
  assign a_if.rsp_ready = d_rrdy[0];
  assign b_if.req_valid = d_valid[1];
  assign b_if.req_we    = d_we[1];
  assign b_if.req_addr  = d_addr[1];
  assign b_if.req_wdata = d_wdata[1];
  assign b_if.rsp_ready = d_rrdy[1];

  logic          q_rdy [2];
  logic          q_rv  [2];
  logic [DW-1:0] q_rd  [2];
  logic          q_err [2];
  assign q_rdy[0] = a_if.req_ready;
  assign q_rdy[1] = b_if.req_ready;
  assign q_rv[0]  = a_if.rsp_valid;
  assign q_rv[1]  = b_if.rsp_valid;
  assign q_rd[0]  = a_if.rsp_rdata;
  assign q_rd[1]  = b_if.rsp_rdata;
  assign q_err[0] = a_if.rsp_err;
  assign q_err[1] = b_if.rsp_err;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: memory image, pending response per port, counter
  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_pend  [2];
  logic [DW-1:0] m_rdata [2];
  bit            m_err   [2];
  bit            m_acc   [2];
  int unsigned   m_cnt;

  function automatic bit m_coll();
    return d_valid[0] && d_valid[1] && d_we[0] && d_we[1] &&
           (d_addr[0] == d_addr[1]) && (int'(d_addr[0]) < int'(DEPTH));
  endfunction

  function automatic bit m_ready(input int p);
    bit lose;
    lose = m_coll() && (p == 1);
    return !lose && (!m_pend[p] || d_rrdy[p]);
  endfunction

  always @(posedge clk) begin
    bit acc [2];
    if (rstn) begin
      for (int p = 0; p < 2; p++) acc[p] = d_valid[p] && m_ready(p);
      for (int p = 0; p < 2; p++) if (m_pend[p] && d_rrdy[p]) m_pend[p] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (acc[p] && !d_we[p]) begin
          m_pend[p]  = 1'b1;
          m_err[p]   = int'(d_addr[p]) >= int'(DEPTH);
          m_rdata[p] = m_err[p] ? '0 : m_mem[d_addr[p]];
        end
      end
      for (int p = 0; p < 2; p++)
        if (acc[p] && d_we[p] && (int'(d_addr[p]) < int'(DEPTH))) m_mem[d_addr[p]] = d_wdata[p];
      if (m_coll() && m_cnt < 32'hFFFF) m_cnt++;
      m_acc = acc;
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      for (int p = 0; p < 2; p++) begin
        if (d_valid[p]) chk($sformatf("p%0d_req_ready", p), 64'(q_rdy[p]), 64'(m_ready(p)));
        chk($sformatf("p%0d_rsp_valid", p), 64'(q_rv[p]), 64'(m_pend[p]));
        if (m_pend[p]) begin
          chk($sformatf("p%0d_rsp_rdata", p), 64'(q_rd[p]), 64'(m_rdata[p]));
          chk($sformatf("p%0d_rsp_err", p), 64'(q_err[p]), 64'(m_err[p]));
        end
      end
      chk("coll_cnt", 64'(coll_cnt), 64'(m_cnt));
    end
  end

  function automatic logic [DW-1:0] fill_val(input int a);
    return 32'hC0DE_0000 + DW'(a);
  endfunction

  task automatic issue(input int p, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    d_valid[p] = 1'b1;
    d_we[p]    = we;
    d_addr[p]  = addr;
    d_wdata[p] = data;
  endtask

  // Advance until every pending request is accepted, bounded.
  task automatic wait_done();
    int n = 0;
    while ((d_valid[0] || d_valid[1]) && n < 64) begin
      @(posedge clk); #1;
      n++;
      for (int p = 0; p < 2; p++) if (m_acc[p]) d_valid[p] = 1'b0;
    end
    if (d_valid[0] || d_valid[1]) begin
      chk("accept_timeout", 64'd0, 64'd1);
      d_valid[0] = 1'b0;
      d_valid[1] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return 8'h10;
      1: return 8'h20;
      2: return 8'h30;
      3: return 8'hC7;
      4: return 8'hC8;
      default: return AW'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    for (int p = 0; p < 2; p++) begin
      d_valid[p] = 1'b0; d_we[p] = 1'b0; d_addr[p] = '0; d_wdata[p] = '0; d_rrdy[p] = 1'b1;
      m_pend[p] = 1'b0; m_err[p] = 1'b0; m_acc[p] = 1'b0; m_rdata[p] = '0;
    end
    m_cnt = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_rsp_valid", 64'(a_if.rsp_valid), 64'd0);
    chk("rst_b_rsp_valid", 64'(b_if.rsp_valid), 64'd0);
    chk("rst_a_rdata", 64'(a_if.rsp_rdata), 64'd0);
    chk("rst_coll_cnt", 64'(coll_cnt), 64'd0);
    rstn = 1'b1;

    for (int k = 0; k < int'(DEPTH); k += 2) begin
      issue(0, 1'b1, AW'(k), fill_val(k));
      issue(1, 1'b1, AW'(k + 1), fill_val(k + 1));
      wait_done();
    end
    idle(2);

    // Write then read back on A, one-cycle read latency
    issue(0, 1'b1, 8'h10, 32'hDEADBEEF); wait_done();
    issue(0, 1'b0, 8'h10, '0);           wait_done();
    #1;
    chk("t1_a_rsp_valid", 64'(a_if.rsp_valid), 64'd1);
    chk("t1_a_rdata", 64'(a_if.rsp_rdata), 64'hDEADBEEF);
    chk("t1_a_err", 64'(a_if.rsp_err), 64'd0);
    idle(2);

    // Same-address write collision, A has priority
    issue(0, 1'b1, 8'h20, 32'h1111);
    issue(1, 1'b1, 8'h20, 32'h2222);
    #1;
    chk("t2_b_ready", 64'(b_if.req_ready), 64'd0);
    chk("t2_a_ready", 64'(a_if.req_ready), 64'd1);
    wait_done();
    chk("t2_coll_cnt", 64'(coll_cnt), 64'd1);
    issue(0, 1'b0, 8'h20, '0); wait_done();
    #1;
    chk("t2_rd_0x20", 64'(a_if.rsp_rdata), 64'h2222);
    idle(2);

    // Read and write to the same address in one cycle: read sees old data
    issue(0, 1'b1, 8'h30, 32'h5); wait_done();
    issue(0, 1'b0, 8'h30, '0);
    issue(1, 1'b1, 8'h30, 32'h7);
    wait_done();
    #1;
    chk("t3_a_old_data", 64'(a_if.rsp_rdata), 64'h5);
    issue(0, 1'b0, 8'h30, '0); wait_done();
    #1;
    chk("t3_a_new_data", 64'(a_if.rsp_rdata), 64'h7);
    chk("t3_coll_cnt", 64'(coll_cnt), 64'd1);
    idle(2);

    // Response back-pressure on A while B proceeds
    d_rrdy[0] = 1'b0;
    issue(0, 1'b0, 8'h10, '0); wait_done();
    issue(0, 1'b0, 8'h20, '0);
    issue(1, 1'b0, 8'h30, '0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_a_rsp_valid", 64'(a_if.rsp_valid), 64'd1);
      chk("t4_a_rdata_hold", 64'(a_if.rsp_rdata), 64'hDEADBEEF);
      chk("t4_a_ready", 64'(a_if.req_ready), 64'd0);
      @(posedge clk); #1;
      if (m_acc[1]) d_valid[1] = 1'b0;
      if (i == 0) begin
        #1;
        chk("t4_b_rsp_valid", 64'(b_if.rsp_valid), 64'd1);
        chk("t4_b_rdata", 64'(b_if.rsp_rdata), 64'h7);
      end
    end
    d_rrdy[0] = 1'b1;
    #1;
    chk("t4_a_ready_release", 64'(a_if.req_ready), 64'd1);
    wait_done();
    #1;
    chk("t4_a_back_to_back", 64'(a_if.rsp_rdata), 64'h2222);
    chk("t4_a_rsp_valid2", 64'(a_if.rsp_valid), 64'd1);
    idle(2);

    // Out-of-range addresses and the DEPTH boundary
    issue(1, 1'b0, 8'hF0, '0); wait_done();
    #1;
    chk("t5_b_err", 64'(b_if.rsp_err), 64'd1);
    chk("t5_b_rdata", 64'(b_if.rsp_rdata), 64'd0);
    issue(1, 1'b1, 8'hF0, 32'hFFFFFFFF); wait_done();
    issue(1, 1'b0, 8'h28, '0); wait_done();
    #1;
    chk("t5_no_alias", 64'(b_if.rsp_rdata), 64'(fill_val(40)));
    issue(1, 1'b0, 8'hC7, '0); wait_done();
    #1;
    chk("t5_last_err", 64'(b_if.rsp_err), 64'd0);
    chk("t5_last_rdata", 64'(b_if.rsp_rdata), 64'(fill_val(199)));
    issue(1, 1'b0, 8'hC8, '0); wait_done();
    #1;
    chk("t5_first_oor_err", 64'(b_if.rsp_err), 64'd1);
    idle(2);

    // Asynchronous reset while a response is held
    d_rrdy[0] = 1'b0;
    issue(0, 1'b0, 8'h10, '0); wait_done();
    #1;
    chk("t6_pre_rsp_valid", 64'(a_if.rsp_valid), 64'd1);
    rstn = 1'b0;
    for (int p = 0; p < 2; p++) begin m_pend[p] = 1'b0; m_acc[p] = 1'b0; end
    m_cnt = 0;
    #1;
    chk("t6_rst_rsp_valid", 64'(a_if.rsp_valid), 64'd0);
    chk("t6_rst_rdata", 64'(a_if.rsp_rdata), 64'd0);
    chk("t6_rst_err", 64'(a_if.rsp_err), 64'd0);
    chk("t6_rst_coll_cnt", 64'(coll_cnt), 64'd0);
    d_rrdy[0] = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b1;
    issue(0, 1'b0, 8'h20, '0); wait_done();
    #1;
    chk("t6_post_rst_rd", 64'(a_if.rsp_rdata), 64'h2222);
    idle(2);

    // Random traffic on both ports
    for (int c = 0; c < 4000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!d_valid[p] && $urandom_range(0, 3) != 0)
          issue(p, 1'($urandom_range(0, 1)), pick_addr(), $urandom());
        d_rrdy[p] = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) if (m_acc[p]) d_valid[p] = 1'b0;
    end
    d_rrdy[0] = 1'b1;
    d_rrdy[1] = 1'b1;
    wait_done();
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
